mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencing controller for the multiply/divide unit in the execute stage of the pipelined MIPS core. It accepts one HI/LO-class instruction at a time, computes the result, holds it for a fixed multi-cycle latency, and then commits it to the architectural HI/LO registers. While an operation is in flight it drives `busy`, which the hazard unit uses to stall later HI/LO instructions. An exception kill input suppresses commitment of an operation in the issue cycle, so precise exceptions hold.

## Interface
Parameters:
- `MUL_LAT`, 5: cycles `busy` stays high for MULT/MULTU (and MADD/MSUB family).
- `DIV_LAT`, 10: cycles `busy` stays high for DIV/DIVU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  valid HI/LO-class instruction in E stage this cycle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB (6/7 only with macro); otherwise no-op.
- `kill`  in  1  exception/interrupt flush this cycle; ignores `start`.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `busy`  out  1  operation in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Accept condition: `start & ~kill & ~busy`. When `start` is high while `busy` is high, the input is ignored. The pipeline must not present it.
- State machine has two states, IDLE and RUN.
  - IDLE -> RUN on an accepted MULT/MULTU/DIV/DIVU/MADD/MSUB.
  - RUN -> IDLE when the counter reaches 1. HI/LO are committed on that edge.
- On accept, the result is computed combinationally and latched into `pend_hi`/`pend_lo`. The counter loads `MUL_LAT` or `DIV_LAT`.
- MTHI/MTLO: accepted in IDLE only. They write `A` to HI/LO at the next edge. They do not assert `busy` and do not enter RUN.
- Multiplies:
  - MULT: signed 64-bit product, {HI,LO}.
  - MULTU: unsigned 64-bit product, {HI,LO}.
- Divides:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU is the unsigned form.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0): the operation runs its full `DIV_LAT` cycles, but HI/LO keep their prior values.
- `kill` arrives only in the issue cycle. An operation already in RUN always completes, because its instruction has passed the exception point.
- Reset mid-operation: state returns to IDLE, the counter is cleared, the pending result is discarded, and HI/LO are zeroed.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `busy` is registered. For an accept at edge 0:
  - `busy` is high from after edge 0 through edge L, where L is the latency.
  - HI/LO update at edge L.
  - `busy` is low after edge L.
  - The next op can be accepted in the cycle after edge L.
- MTHI/MTLO latency: 1 edge. The new value is visible on `hi`/`lo` the cycle after issue.
- `hi`/`lo` reads are direct register outputs. There is no bypass of pending results; the hazard unit stalls MFHI/MFLO while `busy`.
- When `start` and `kill` are asserted together, nothing changes, including for MTHI/MTLO.

## Configuration
- `MDU_MADD_EN` defined:
  - op 6 MADD computes {HI,LO} += signed A*B.
  - op 7 MSUB computes {HI,LO} -= signed A*B.
  - Both use `MUL_LAT`, with the accumulation base being {HI,LO} sampled at accept.
- `MDU_MADD_EN` undefined: ops 6/7 are treated as no-ops. They are not accepted, `busy` stays low, and HI/LO are unchanged.

## Structure
- Package `mdu_pkg`:
  - op encoding localparams (`MDU_MULT`..`MDU_MSUB`);
  - state encoding (`MDU_IDLE`, `MDU_RUN`);
  - default latency constants.
- Sub-module `mdu_calc`: purely combinational. It takes op, A, B and the current {HI,LO}, and produces the 64-bit result plus a `div0` flag.
- `mdu_ctrl` holds the FSM, the counter, the pending registers and the HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFE(-2), B=3 -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV A=-7, B=2 -> `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands gives LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678 then DIV by B=0 -> after 10 cycles HI=0x12345678 and LO unchanged.
- `start`+`kill` on MULT A=2,B=2 -> `busy` never rises, HI/LO unchanged. A new `start` issued mid-RUN is ignored and the original result commits.
- `reset` pulse asynchronously in cycle 3 of a DIV -> `busy`, HI and LO go to 0 immediately, and no commit occurs afterward.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADD A=1,B=1 -> HI=1, LO=0. Without the macro: op 6 leaves `busy`=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
// MDU_MADD_EN enables the MADD/MSUB accumulate ops (6/7); otherwise they decode as no-ops.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MSUB  = 3'd7;

  localparam int unsigned MDU_MUL_LAT_DEF = 5;
  localparam int unsigned MDU_DIV_LAT_DEF = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic mdu_is_run(input logic [2:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU) || mdu_is_div(op);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MSUB);
`else
    r = r;
`endif
    return r;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit product/quotient-remainder/accumulate result and div-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [63:0] i_hilo,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic               w_bzero;
  logic               w_ovf;
  logic [31:0]        w_bu;
  logic [31:0]        w_bs;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;

  assign w_bzero = (i_b == '0);
  assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Divisor of 1 for /0 (result discarded) and for INT_MIN/-1, where a /1 yields exactly the wrapped quotient and zero remainder.
  assign w_bu = w_bzero ? 32'd1 : i_b;
  assign w_bs = (w_bzero || w_ovf) ? 32'd1 : i_b;

  assign w_sq = $signed(i_a) / $signed(w_bs);
  assign w_sr = $signed(i_a) % $signed(w_bs);
  assign w_uq = i_a / w_bu;
  assign w_ur = i_a % w_bu;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  always_comb begin
    o_result = '0;
    o_div0   = mdu_is_div(i_op) && w_bzero;
    case (i_op)
      MDU_MULT:  o_result = w_sprod;
      MDU_MULTU: o_result = w_uprod;
      MDU_DIV:   o_result = {w_sr, w_sq};
      MDU_DIVU:  o_result = {w_ur, w_uq};
      MDU_MADD:  o_result = i_hilo + w_sprod;
      MDU_MSUB:  o_result = i_hilo - w_sprod;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO sequencing controller: accepts one op, holds the result for MUL_LAT/DIV_LAT cycles, then commits.
// MDU_MADD_EN (see mdu_pkg) adds MADD/MSUB accumulate ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MDU_MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = MDU_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        kill,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  mdu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_div0;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic [63:0] w_result;
  logic        w_div0;

  assign w_accept = start & ~kill & ~r_busy;

  mdu_calc u_calc (
    .i_op     (op),
    .i_a      (A),
    .i_b      (B),
    .i_hilo   ({r_hi, r_lo}),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= MDU_IDLE;
      r_cnt       <= '0;
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_pend_div0 <= 1'b0;
      r_busy      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            if (mdu_is_run(op)) begin
              r_state     <= MDU_RUN;
              r_busy      <= 1'b1;
              r_cnt       <= mdu_is_div(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
              r_pend_hi   <= w_result[63:32];
              r_pend_lo   <= w_result[31:0];
              r_pend_div0 <= w_div0;
            end else if (op == MDU_MTHI) begin
              r_hi <= A;
            end else if (op == MDU_MTLO) begin
              r_lo <= A;
            end
          end
        end
        MDU_RUN: begin
          if (r_cnt == CW'(1)) begin
            r_state <= MDU_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            if (!r_pend_div0) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= MDU_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default latencies 5/10).
module tb_mdu_ctrl;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        kill;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .kill  (kill),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic k);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; kill = k;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0; op = 3'd0; A = '0; B = '0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mthi_mtlo;
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0);
    n_tests++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi_hi got=%h exp=a5a5a5a5", hi); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    issue(OP_MTLO, 32'h5A5A_5A5A, 32'h0, 1'b0);
    n_tests++; if (lo !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL mtlo_lo got=%h exp=5a5a5a5a", lo); end
    n_tests++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mtlo_hi_kept got=%h exp=a5a5a5a5", hi); end
  endtask

  task automatic test_mult;
    int c;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_rise got=%b exp=1", busy); end
    n_tests++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mult_no_bypass got=%h exp=a5a5a5a5", hi); end
    wait_idle(c);
    n_tests++; if (c !== 5) begin n_fail++; $display("FAIL mult_latency got=%0d exp=5", c); end
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    n_tests++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_multu;
    int c;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(c);
    n_tests++; if (c !== 5) begin n_fail++; $display("FAIL multu_latency got=%0d exp=5", c); end
    n_tests++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    n_tests++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_div;
    int c;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(c);
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL div_latency got=%0d exp=10", c); end
    n_tests++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(c);
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL divu_latency got=%0d exp=10", c); end
    n_tests++; if (lo !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_lo got=%h exp=7ffffffc", lo); end
    n_tests++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_idle(c);
    n_tests++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdivisor_lo got=%h exp=fffffffd", lo); end
    n_tests++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negdivisor_hi got=%h exp=00000001", hi); end
  endtask

  task automatic test_div_overflow;
    int c;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(c);
    n_tests++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    n_tests++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(c);
    n_tests++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL divu_big_lo got=%h exp=00000000", lo); end
    n_tests++; if (hi !== 32'h8000_0000) begin n_fail++; $display("FAIL divu_big_hi got=%h exp=80000000", hi); end
  endtask

  task automatic test_div0;
    int c;
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    issue(OP_DIV, 32'd55, 32'd0, 1'b0);
    wait_idle(c);
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL div0_latency got=%0d exp=10", c); end
    n_tests++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL div0_hi got=%h exp=12345678", hi); end
    n_tests++; if (lo !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL div0_lo got=%h exp=deadbeef", lo); end
    issue(OP_DIVU, 32'd9, 32'd0, 1'b0);
    wait_idle(c);
    n_tests++; if ({hi, lo} !== 64'h1234_5678_DEAD_BEEF) begin n_fail++; $display("FAIL divu0_hilo got=%h exp=12345678deadbeef", {hi, lo}); end
  endtask

  task automatic test_kill;
    issue(OP_MULT, 32'd2, 32'd2, 1'b1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy_later got=%b exp=0", busy); end
    n_tests++; if ({hi, lo} !== 64'h1234_5678_DEAD_BEEF) begin n_fail++; $display("FAIL kill_mult_hilo got=%h exp=12345678deadbeef", {hi, lo}); end
    issue(OP_MTHI, 32'h1111_1111, 32'h0, 1'b1);
    n_tests++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL kill_mthi_hi got=%h exp=12345678", hi); end
  endtask

  task automatic test_midrun_start;
    int c;
    issue(OP_MULT, 32'd3, 32'd4, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    wait_idle(c);
    n_tests++; if (c !== 2) begin n_fail++; $display("FAIL midrun_remaining got=%0d exp=2", c); end
    n_tests++; if ({hi, lo} !== 64'd12) begin n_fail++; $display("FAIL midrun_hilo got=%h exp=000000000000000c", {hi, lo}); end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_no_second got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int c;
    issue(OP_MULT, 32'd5, 32'd6, 1'b0);
    wait_idle(c);
    n_tests++; if (lo !== 32'd30) begin n_fail++; $display("FAIL b2b_first_lo got=%h exp=0000001e", lo); end
    issue(OP_MULTU, 32'd7, 32'd8, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_idle(c);
    n_tests++; if (c !== 5) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=5", c); end
    n_tests++; if ({hi, lo} !== 64'd56) begin n_fail++; $display("FAIL b2b_second_hilo got=%h exp=0000000000000038", {hi, lo}); end
  endtask

  task automatic test_reset_mid;
    issue(OP_DIV, 32'd100, 32'd3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
    n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
    n_tests++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rstmid_no_commit got=%h exp=0", {hi, lo}); end
  endtask

  task automatic test_madd;
    int c;
    issue(OP_MTHI, 32'h0, 32'h0, 1'b0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
`ifdef MDU_MADD_EN
    issue(OP_MADD, 32'd1, 32'd1, 1'b0);
    wait_idle(c);
    n_tests++; if (c !== 5) begin n_fail++; $display("FAIL madd_latency got=%0d exp=5", c); end
    n_tests++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL madd_hilo got=%h exp=0000000100000000", {hi, lo}); end
    issue(OP_MSUB, 32'd2, 32'd3, 1'b0);
    wait_idle(c);
    n_tests++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFA) begin n_fail++; $display("FAIL msub_hilo got=%h exp=00000000fffffffa", {hi, lo}); end
    issue(OP_MADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_idle(c);
    n_tests++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFF9) begin n_fail++; $display("FAIL madd_neg_hilo got=%h exp=00000000fffffff9", {hi, lo}); end
`else
    issue(OP_MADD, 32'd1, 32'd1, 1'b0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op6_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_tests++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL op6_hilo got=%h exp=00000000ffffffff", {hi, lo}); end
    issue(OP_MSUB, 32'd2, 32'd3, 1'b0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op7_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_tests++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL op7_hilo got=%h exp=00000000ffffffff", {hi, lo}); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; kill = 1'b0; A = '0; B = '0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_div0();
    test_kill();
    test_midrun_start();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
